// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and multi-cycle
// mul/div stalls, plus saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_mc_start,
  input  logic        ex_mc_is_div,
  input  logic        ex_br_taken,
  input  logic        clr_cnt,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mc_busy,
  output logic        ex_mc_done,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;
  // The start cycle and the done cycle are not counted down, hence N-2.
  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 2);
  localparam logic [3:0] DIV_LOAD   = 4'(DIV_CYCLES - 2);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [3:0]  r_mc_cnt;
  logic [3:0]  w_mc_cnt_nxt;
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;
  logic        w_lu;
  logic        w_pc_stall;
  logic        w_if_id_stall;
  logic        w_id_ex_stall;
  logic        w_if_id_flush;
  logic        w_id_ex_flush;
  logic        w_mc_busy;
  logic        w_mc_done;

  assign w_lu = ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_id_ex_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_mc_busy     = 1'b0;
    w_mc_done     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (ex_br_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (ex_valid && ex_mc_start) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_stall = 1'b1;
          w_mc_busy     = 1'b1;
          w_mc_cnt_nxt  = ex_mc_is_div ? DIV_LOAD : MUL_LOAD;
          w_state_nxt   = ST_MC_BUSY;
        end else if (w_lu) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end else begin
          w_state_nxt   = ST_RUN;
        end
      end
      // Branches, new starts and load-use are deliberately ignored while busy.
      ST_MC_BUSY: begin
        if (r_mc_cnt != 4'd0) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_stall = 1'b1;
          w_mc_busy     = 1'b1;
          w_mc_cnt_nxt  = r_mc_cnt - 4'd1;
        end else begin
          w_mc_done     = 1'b1;
          w_state_nxt   = ST_RUN;
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_mc_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Reset must silence every control output even though the logic is combinational.
  assign pc_stall     = rst_n & w_pc_stall;
  assign if_id_stall  = rst_n & w_if_id_stall;
  assign id_ex_stall  = rst_n & w_id_ex_stall;
  assign if_id_flush  = rst_n & w_if_id_flush;
  assign id_ex_flush  = rst_n & w_id_ex_flush;
  assign ex_mc_busy   = rst_n & w_mc_busy;
  assign ex_mc_done   = rst_n & w_mc_done;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
    end else if (clr_cnt) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
    end else begin
      if (pc_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (if_id_flush && (r_flush_events != 16'hFFFF)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed
// multi-cycle sequences and random stimulus against a remaining-cycles model.
module tb_hazard_control_unit;

  localparam int MULN = 3;
  localparam int DIVN = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_valid, ex_MemRead, ex_mc_start, ex_mc_is_div;
  logic ex_br_taken, clr_cnt;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mc_busy, ex_mc_done;
  logic [15:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles of the multi-cycle op still ahead, and counters.
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_control_unit #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_mc_start(ex_mc_start), .ex_mc_is_div(ex_mc_is_div), .ex_br_taken(ex_br_taken),
    .clr_cnt(clr_cnt),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mc_busy(ex_mc_busy), .ex_mc_done(ex_mc_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, v, mr, st, dv, br;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  // Output bundle order: {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, busy, done}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_BR   = 7'b0001100;
  localparam logic [6:0] O_MC   = 7'b1110010;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_DONE = 7'b0000001;

  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mc_busy, ex_mc_done};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_out();
    bit lu;
    lu = ex_valid && ex_MemRead && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_left > 1) return O_MC;
    if (m_left == 1) return O_DONE;
    if (ex_br_taken) return O_BR;
    if (ex_valid && ex_mc_start) return O_MC;
    if (lu) return O_LU;
    return O_NONE;
  endfunction

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic v, input logic [4:0] rd, input logic mr, input logic st,
                       input logic dv, input logic br, input logic cl);
    id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2; ex_valid = v; ex_rd = rd;
    ex_MemRead = mr; ex_mc_start = st; ex_mc_is_div = dv; ex_br_taken = br; clr_cnt = cl;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: compare against model (and an optional explicit value), advance model.
  task automatic step(input bit use_exp, input logic [6:0] exp, input string nm);
    logic [6:0] e;
    #2;
    e = m_out();
    chk("ctrl_model", {9'd0, outs()}, {9'd0, e});
    if (use_exp) chk(nm, {9'd0, outs()}, {9'd0, exp});
    chk("stall_cycles", stall_cycles, 16'(m_stall));
    chk("flush_events", flush_events, 16'(m_flush));
    if (clr_cnt) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e[6] && m_stall < 65535) m_stall++;
      if (e[3] && m_flush < 65535) m_flush++;
    end
    if (m_left > 0) m_left--;
    else if (!ex_br_taken && ex_valid && ex_mc_start) m_left = (ex_mc_is_div ? DIVN : MULN) - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    idle(); clr_cnt = 1'b1;
    step(1'b0, O_NONE, "clr");
    clr_cnt = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
    tbl[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[2]  = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    tbl[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
    tbl[4]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
    tbl[5]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
    tbl[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
    tbl[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BR};
    tbl[8]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_BR};
    tbl[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, O_BR};
    tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE};
    tbl[11] = '{5'd9, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};

    // Reset with hostile inputs: everything must read 0.
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("reset_ctrl", {9'd0, outs()}, 16'd0);
    chk("reset_stall_cnt", stall_cycles, 16'd0);
    chk("reset_flush_cnt", flush_events, 16'd0);
    @(posedge clk); #1;
    idle(); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].v, tbl[i].rd,
            tbl[i].mr, tbl[i].st, tbl[i].dv, tbl[i].br, 1'b0);
      step(1'b1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Load-use gives exactly one bubble; ex_rd=0 gives none.
    clear_counters();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, O_LU, "lu_x5");
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, O_NONE, "lu_x0");
    #2; chk("lu_stall_cnt", stall_cycles, 16'd1); #0;
    @(posedge clk); #1;

    // Multiply, start held high during busy to show it is ignored.
    clear_counters();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, O_MC, "mul_c0");
    step(1'b1, O_MC, "mul_c1");
    step(1'b1, O_DONE, "mul_c2");
    idle();
    step(1'b1, O_NONE, "mul_after");
    chk("mul_stall_cnt", stall_cycles, 16'd2);

    // Divide with a taken branch and load-use mid-op.
    clear_counters();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, O_MC, "div_c0");
    idle();
    for (int c = 1; c < 7; c++) begin
      if (c == 3) ex_br_taken = 1'b1;
      else if (c == 4) drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else idle();
      step(1'b1, O_MC, $sformatf("div_c%0d", c));
    end
    idle();
    step(1'b1, O_DONE, "div_c7");
    step(1'b1, O_NONE, "div_after");
    chk("div_stall_cnt", stall_cycles, 16'd7);
    chk("div_flush_cnt", flush_events, 16'd0);

    // Branch beats load-use.
    clear_counters();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, O_BR, "br_lu");
    idle();
    step(1'b1, O_NONE, "br_lu_after");
    chk("br_lu_flush_cnt", flush_events, 16'd1);
    chk("br_lu_stall_cnt", stall_cycles, 16'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 49) == 0));
      step(1'b0, O_NONE, "rnd");
    end

    // Saturation, then clear while stalling.
    clear_counters();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 70000; n++) step(1'b0, O_NONE, "sat");
    chk("sat_stall_cnt", stall_cycles, 16'hFFFF);
    clr_cnt = 1'b1;
    step(1'b1, O_LU, "clr_while_stall");
    clr_cnt = 1'b0;
    chk("clr_stall_cnt", stall_cycles, 16'd0);

    // Reset in the middle of a divide (mc_cnt = 4).
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, O_MC, "rdiv_c0");
    idle();
    step(1'b1, O_MC, "rdiv_c1");
    step(1'b1, O_MC, "rdiv_c2");
    ex_br_taken = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_ctrl", {9'd0, outs()}, 16'd0);
    chk("rst_mid_stall_cnt", stall_cycles, 16'd0);
    chk("rst_mid_flush_cnt", flush_events, 16'd0);
    m_left = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    idle(); rst_n = 1'b1;
    step(1'b1, O_NONE, "post_rst_idle");
    ex_br_taken = 1'b1;
    step(1'b1, O_BR, "post_rst_br");
    idle();
    step(1'b1, O_NONE, "post_rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
